crc8_frame_checker: RTL and testbench
=====================================

Name: crc8_frame_checker

Overview:
- Receive-side companion to the team's serial CRC8 generator (polynomial 0xD5, init 0x00, no final XOR, MSB-first).
- Accepts a serial frame of PAYLOAD_BITS payload bits followed by an 8-bit CRC field, MSB first.
- Recomputes the CRC over the payload, captures the received CRC, and reports pass/fail with a one-cycle DONE pulse.
- Sits between the bit-level deserializer and the frame consumer.

Parameters:
- PAYLOAD_BITS, 64: number of payload bits per frame, range 1..1024.
- POLY, 8'hD5: CRC polynomial with implicit x^8. Bit i set means an XOR tap into CRC[i].
- INIT, 8'h00: LFSR value loaded at START.

Ports:
- BITSTRB  input  1  clock; all state changes on its rising edge.
- CLEAR  input  1  asynchronous, active-high reset.
- START  input  1  begin a new frame; sampled at the BITSTRB edge.
- ENABLE  input  1  BITVAL is valid and consumed on this edge.
- BITVAL  input  1  serial data bit.
- BUSY  output  1  high while in PAYLOAD or CRCFIELD.
- DONE  output  1  one-cycle pulse at frame end.
- CRC_OK  output  1  last frame passed; held until next START or CLEAR.
- CRC_ERR  output  1  last frame failed; held until next START or CLEAR.
- CALC_CRC  output  8  LFSR value, running during payload and frozen afterwards.
- RX_CRC  output  8  received CRC field, shifted in MSB first.

Behaviour:
- States: IDLE, PAYLOAD, CRCFIELD, DONE. An internal bit counter is wide enough for PAYLOAD_BITS.
- CLEAR (asynchronous, any state):
  - state goes to IDLE, counter to 0;
  - CALC_CRC = INIT, RX_CRC = 0;
  - BUSY, DONE, CRC_OK, CRC_ERR all 0.
- LFSR step per consumed payload bit: inv = BITVAL ^ CALC_CRC[7]; CALC_CRC = (CALC_CRC << 1) ^ (inv ? POLY : 0). This is bit-exact with the generator.
- START (any state, highest priority after CLEAR):
  - go to PAYLOAD; CALC_CRC = INIT, RX_CRC = 0, counter = 0;
  - CRC_OK, CRC_ERR and DONE cleared;
  - ENABLE/BITVAL on the same edge are ignored.
  - START during BUSY aborts the current frame with no DONE pulse.
- PAYLOAD:
  - each edge with ENABLE=1 steps the LFSR and increments the counter.
  - The edge consuming bit PAYLOAD_BITS moves to CRCFIELD and resets the counter.
  - ENABLE=0 edges hold everything.
- CRCFIELD:
  - each ENABLE=1 edge does RX_CRC = {RX_CRC[6:0], BITVAL}; CALC_CRC is frozen.
  - The edge consuming the 8th CRC bit moves to DONE and sets DONE=1.
  - The compare uses the incoming bit: CRC_OK = ({RX_CRC[6:0],BITVAL} == CALC_CRC), CRC_ERR = the inverse.
- DONE:
  - lasts exactly one cycle; the next edge clears DONE and goes to IDLE.
  - ENABLE is ignored in this state.
- IDLE: ENABLE is ignored; CRC_OK, CRC_ERR, CALC_CRC and RX_CRC hold.
- Latency: DONE, CRC_OK and CRC_ERR are valid in the cycle directly after the edge consuming the last CRC bit.
- CRC_OK and CRC_ERR are never both 1.

Optional Feature:
- Macro: CRC8_CHK_ERRCNT_EN.
- Defined: adds output ERR_COUNT[7:0].
  - Increments by one on each frame completing with CRC_ERR.
  - Saturates at 255.
  - Reset to 0 by CLEAR only; START does not clear it.
- Undefined: no port and no counter logic.

Test Plan (PAYLOAD_BITS=8, defaults otherwise):
- START, then bits 0x01 and 0xD5 on consecutive ENABLE edges -> CALC_CRC=0xD5, RX_CRC=0xD5, DONE pulses one cycle after the 16th bit, CRC_OK=1, CRC_ERR=0, BUSY=0 afterwards.
- START, payload 0x01, CRC field 0xD4 -> CRC_ERR=1, CRC_OK=0, RX_CRC=0xD4; ERR_COUNT=1 with the macro defined.
- START, payload 0x02 and CRC 0x7F with ENABLE=0 gaps of 0-3 cycles between bits -> CALC_CRC=0x7F, CRC_OK=1, DONE exactly once.
- START, 5 payload bits, assert CLEAR asynchronously between edges -> all outputs 0 immediately; a following clean frame 0x01/0xD5 passes.
- START, 10 bits of a frame, then START with ENABLE=1 on the same edge, then 0x02/0x7F -> no DONE from the aborted frame, the new frame passes, and the bit on the START edge is ignored.
- With the macro defined, 257 bad frames -> ERR_COUNT=255; after CLEAR, ERR_COUNT=0.

Source files
------------

// File: rtl/crc8_frame_checker.sv
// Serial CRC8 frame checker: payload LFSR, CRC field capture, pass/fail.
// Optional CRC8_CHK_ERRCNT_EN adds a saturating ERR_COUNT output.
module crc8_frame_checker #(
    parameter int         PAYLOAD_BITS = 64,
    parameter logic [7:0] POLY         = 8'hD5,
    parameter logic [7:0] INIT         = 8'h00
) (
    input  logic       BITSTRB,
    input  logic       CLEAR,
    input  logic       START,
    input  logic       ENABLE,
    input  logic       BITVAL,
    output logic       BUSY,
    output logic       DONE,
    output logic       CRC_OK,
    output logic       CRC_ERR,
    output logic [7:0] CALC_CRC,
    output logic [7:0] RX_CRC
`ifdef CRC8_CHK_ERRCNT_EN
    ,
    output logic [7:0] ERR_COUNT
`endif
);

    // Counter also walks the 8-bit CRC field, so never narrower than 3 bits.
    localparam int CW = (PAYLOAD_BITS > 8) ? $clog2(PAYLOAD_BITS) : 3;
    localparam logic [CW-1:0] LAST_PAY = CW'(PAYLOAD_BITS - 1);
    localparam logic [CW-1:0] LAST_CRC = CW'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CRCFIELD,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          inv;
    logic [7:0]    rx_next;
    logic          match;

    assign inv     = BITVAL ^ CALC_CRC[7];
    assign rx_next = {RX_CRC[6:0], BITVAL};
    assign match   = (rx_next == CALC_CRC);

    always_ff @(posedge BITSTRB or posedge CLEAR) begin
        if (CLEAR) begin
            state    <= S_IDLE;
            cnt      <= '0;
            CALC_CRC <= INIT;
            RX_CRC   <= 8'h00;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            CRC_OK   <= 1'b0;
            CRC_ERR  <= 1'b0;
`ifdef CRC8_CHK_ERRCNT_EN
            ERR_COUNT <= 8'h00;
`endif
        end else if (START) begin
            state    <= S_PAYLOAD;
            cnt      <= '0;
            CALC_CRC <= INIT;
            RX_CRC   <= 8'h00;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
            CRC_OK   <= 1'b0;
            CRC_ERR  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: state <= S_IDLE;
                S_PAYLOAD: begin
                    if (ENABLE) begin
                        CALC_CRC <= {CALC_CRC[6:0], 1'b0} ^ (inv ? POLY : 8'h00);
                        if (cnt == LAST_PAY) begin
                            cnt   <= '0;
                            state <= S_CRCFIELD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_CRCFIELD: begin
                    if (ENABLE) begin
                        RX_CRC <= rx_next;
                        if (cnt == LAST_CRC) begin
                            cnt     <= '0;
                            state   <= S_DONE;
                            BUSY    <= 1'b0;
                            DONE    <= 1'b1;
                            CRC_OK  <= match;
                            CRC_ERR <= ~match;
`ifdef CRC8_CHK_ERRCNT_EN
                            if (!match && ERR_COUNT != 8'hFF)
                                ERR_COUNT <= ERR_COUNT + 8'd1;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Bench for crc8_frame_checker: vector table, corner sequences, random frames.
module tb_crc8_frame_checker;

    logic       BITSTRB = 1'b0;
    logic       CLEAR;
    logic       START;
    logic       ENABLE;
    logic       BITVAL;
    logic       BUSY;
    logic       DONE;
    logic       CRC_OK;
    logic       CRC_ERR;
    logic [7:0] CALC_CRC;
    logic [7:0] RX_CRC;
`ifdef CRC8_CHK_ERRCNT_EN
    logic [7:0] ERR_COUNT;
`endif

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;
    int err_model = 0;

    crc8_frame_checker #(.PAYLOAD_BITS(8)) dut (
        .BITSTRB (BITSTRB),
        .CLEAR   (CLEAR),
        .START   (START),
        .ENABLE  (ENABLE),
        .BITVAL  (BITVAL),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .CRC_OK  (CRC_OK),
        .CRC_ERR (CRC_ERR),
        .CALC_CRC(CALC_CRC),
        .RX_CRC  (RX_CRC)
`ifdef CRC8_CHK_ERRCNT_EN
        ,
        .ERR_COUNT(ERR_COUNT)
`endif
    );

    always #5 BITSTRB = ~BITSTRB;

    always @(negedge BITSTRB) if (DONE) done_seen++;

    // Reference: remainder of payload * x^8 divided by x^8 + POLY.
    function automatic logic [7:0] crc_ref(input logic [7:0] p);
        logic [15:0] d;
        d = {p, 8'h00};
        for (int i = 15; i >= 8; i--)
            if (d[i]) d = d ^ (16'h01D5 << (i - 8));
        return d[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge BITSTRB);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        ENABLE = 1'b0;
        repeat (gap) tick();
        ENABLE = 1'b1;
        BITVAL = b;
        tick();
        ENABLE = 1'b0;
    endtask

    task automatic frame(input logic [7:0] p, input logic [7:0] c,
                         input int maxgap, input bit start_bit);
        logic [7:0] exp_c;
        logic       ok;
        int         d0;
        d0     = done_seen;
        exp_c  = crc_ref(p);
        ok     = (c == exp_c);
        START  = 1'b1;
        ENABLE = start_bit;
        BITVAL = 1'b1;
        tick();
        START  = 1'b0;
        ENABLE = 1'b0;
        chk("busy_after_start", BUSY, 1);
        chk("flags_clr_start", {DONE, CRC_OK, CRC_ERR}, 0);
        for (int i = 7; i >= 0; i--)
            send_bit(p[i], int'($urandom_range(maxgap, 0)));
        chk("busy_in_crcfield", BUSY, 1);
        for (int i = 7; i >= 0; i--)
            send_bit(c[i], int'($urandom_range(maxgap, 0)));
        chk("done_pulse", DONE, 1);
        chk("crc_ok", CRC_OK, ok);
        chk("crc_err", CRC_ERR, !ok);
        chk("calc_crc", CALC_CRC, exp_c);
        chk("rx_crc", RX_CRC, c);
        chk("busy_end", BUSY, 0);
        if (!ok && err_model < 255) err_model++;
`ifdef CRC8_CHK_ERRCNT_EN
        chk("err_count", ERR_COUNT, err_model);
`endif
        tick();
        chk("done_low", DONE, 0);
        chk("done_once", done_seen - d0, 1);
        ENABLE = 1'b1;
        BITVAL = 1'($urandom);
        tick();
        BITVAL = ~BITVAL;
        tick();
        ENABLE = 1'b0;
        chk("idle_hold", {CALC_CRC, RX_CRC, CRC_OK, CRC_ERR, BUSY, DONE},
            {exp_c, c, ok, !ok, 2'b00});
    endtask

    typedef struct {
        logic [7:0] p;
        logic [7:0] c;
        int         gap;
        logic       ok;
        logic [7:0] calc;
    } vec_t;

    vec_t vt[4];

    initial begin
        vt[0] = '{8'h01, 8'hD5, 0, 1'b1, 8'hD5};
        vt[1] = '{8'h01, 8'hD4, 0, 1'b0, 8'hD5};
        vt[2] = '{8'h02, 8'h7F, 3, 1'b1, 8'h7F};
        vt[3] = '{8'h02, 8'h7E, 2, 1'b0, 8'h7F};

        CLEAR  = 1'b1;
        START  = 1'b0;
        ENABLE = 1'b0;
        BITVAL = 1'b0;
        #3;
        chk("reset_flags", {BUSY, DONE, CRC_OK, CRC_ERR}, 0);
        chk("reset_crcs", {CALC_CRC, RX_CRC}, 0);
        tick();
        CLEAR = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            frame(vt[i].p, vt[i].c, vt[i].gap, 1'b0);
            chk("tbl_calc", CALC_CRC, vt[i].calc);
            chk("tbl_ok", CRC_OK, vt[i].ok);
        end

        // Asynchronous CLEAR part-way through a payload
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        chk("busy_pre_clear", BUSY, 1);
        #2;
        CLEAR = 1'b1;
        #1;
        chk("clear_flags", {BUSY, DONE, CRC_OK, CRC_ERR}, 0);
        chk("clear_crcs", {CALC_CRC, RX_CRC}, 0);
        #1;
        CLEAR = 1'b0;
        err_model = 0;
        tick();
        frame(8'h01, 8'hD5, 0, 1'b0);

        // START mid-frame aborts; bit on the START edge is ignored
        begin
            int d0;
            d0 = done_seen;
            START = 1'b1;
            tick();
            START = 1'b0;
            for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0);
            chk("abort_no_done", done_seen - d0, 0);
            frame(8'h02, 8'h7F, 1, 1'b1);
            chk("abort_total_done", done_seen - d0, 1);
        end

        for (int n = 0; n < 40; n++) begin
            logic [7:0] p;
            logic [7:0] c;
            p = 8'($urandom);
            c = crc_ref(p);
            if ($urandom_range(1, 0) == 1) c = c ^ (8'h01 << $urandom_range(7, 0));
            frame(p, c, 2, 1'($urandom));
        end

`ifdef CRC8_CHK_ERRCNT_EN
        for (int n = 0; n < 257; n++) frame(8'h01, 8'hD4, 0, 1'b0);
        chk("errcnt_sat", ERR_COUNT, 255);
        CLEAR = 1'b1;
        #2;
        chk("errcnt_clear", ERR_COUNT, 0);
        CLEAR = 1'b0;
        err_model = 0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
